// File: rtl/sweep_pkg.sv
// Shared types and helpers for the raster-sweep sequencer.
//   sweep_state_t : sequencer states
//   term_count(n) : terminal count of an n-bit traverse (2^n - 1)
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    STEP_Y,
    DONE
  } sweep_state_t;

  function automatic int unsigned term_count(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Step-rate prescaler for the X axis.
//   clk, rst : clock, synchronous active-high reset
//   load     : latch a new period (0 is treated as 1)
//   period   : clk cycles per tick
//   clear    : force the count back to 0
//   hold     : freeze the count; no tick while held
//   tick     : high in the cycle the count sits at period-1
module tick_divider #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  clear,
  input  logic                  hold,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] period_m1;
  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_m1 <= '0;
      cnt       <= '0;
    end else begin
      if (load)
        period_m1 <= (period == '0) ? '0 : period - 1'b1;
      if (clear)
        cnt <= '0;
      else if (!hold)
        cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && (cnt == period_m1);

endmodule

// File: rtl/sweep_controller.sv
// Raster-sweep sequencer: drives enable/reset of two triangle-wave
// generators so X sweeps edge to edge and Y steps once per X traverse.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a frame (IDLE only); latches period
//   stop       : abort to IDLE
//   pause      : level; freezes the prescaler and step counters in RUN
//   period     : clk cycles per X step (0 behaves as 1)
//   ena_x      : X step strobe
//   ena_y      : Y step strobe
//   gen_rst    : generator reset (one cycle at frame start)
//   busy       : high outside IDLE
//   line       : Y steps issued this frame
//   frame_done : one-cycle pulse at frame end
// Build option: define SWEEP_CONTROLLER_LOOP_EN to sweep frames
// continuously (alternating Y direction) until stop/rst.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  ena_x,
  output logic                  ena_y,
  output logic                  gen_rst,
  output logic                  busy,
  output logic [N-1:0]          line,
  output logic                  frame_done
);

  localparam logic [N-1:0] TERM = N'(term_count(N));

  sweep_state_t   state, state_nx;
  logic [N-1:0]   x_cnt;
  logic           pause_q;
  logic           run_go;
  logic           accept;
  logic           div_clear;
  logic           tick;
  logic           line_end;

  // Pause is taken through a flop so every output stays a pure decode
  // of registered state; it freezes the RUN cycle after it is sampled.
  assign run_go    = (state == RUN) && !pause_q;
  assign accept    = (state == IDLE) && start && !stop;
  assign div_clear = (state == CLEAR) || (state == STEP_Y) || (state == DONE);
  assign line_end  = tick && (x_cnt == TERM - 1'b1);

  tick_divider #(
    .PRESCALE_W(PRESCALE_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .period (period),
    .clear  (div_clear),
    .hold   (!run_go),
    .tick   (tick)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (line_end) state_nx = (line == TERM) ? DONE : STEP_Y;
      STEP_Y:  state_nx = RUN;
`ifdef SWEEP_CONTROLLER_LOOP_EN
      DONE:    state_nx = RUN;
`else
      DONE:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
    if (stop)
      state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x_cnt   <= '0;
      line    <= '0;
      pause_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pause_q <= pause;
      if (state_nx == IDLE || state == CLEAR) begin
        x_cnt <= '0;
        line  <= '0;
      end else begin
        if (tick)
          x_cnt <= line_end ? '0 : x_cnt + 1'b1;
        if (state == STEP_Y && line != TERM)
          line <= line + 1'b1;
`ifdef SWEEP_CONTROLLER_LOOP_EN
        if (state == DONE) begin
          x_cnt <= '0;
          line  <= '0;
        end
`endif
      end
    end
  end

  always_comb begin
    ena_x      = tick;
    ena_y      = (state == STEP_Y);
    gen_rst    = (state == CLEAR);
    frame_done = (state == DONE);
    busy       = (state != IDLE);
  end

endmodule

// File: doc/sweep_controller.md
# sweep_controller

Raster-sweep sequencer for the etch-a-sketch datapath. It drives the `ena` and `rst` inputs of two external N-bit triangle-wave generators, one per axis, so that together they trace a full boustrophedon raster.
- The X generator is stepped at a programmable rate.
- Each time X completes a full edge-to-edge traverse, the Y generator is stepped once.
- A frame completes after Y has traversed its full range.

The block sits between the user/command logic (start/stop/pause) and the coordinate generators feeding the display.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `N`, default 8: coordinate width of the driven generators; one traverse = 2^N-1 steps.
- `PRESCALE_W`, default 16: width of the step-period field.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous active-high reset.
- `start`  in  1: begin a frame; honoured only in IDLE.
- `stop`  in  1: abort; return to IDLE next cycle.
- `pause`  in  1: level; freezes the prescaler and step counters while in RUN.
- `period`  in  PRESCALE_W: clk cycles per X step; sampled on accepted `start`; value 0 is treated as 1.
- `ena_x`  out  1: one-cycle step strobe to the X generator.
- `ena_y`  out  1: one-cycle step strobe to the Y generator.
- `gen_rst`  out  1: reset to both generators.
- `busy`  out  1: high in every state except IDLE.
- `line`  out  N: index of the current line (number of Y steps issued this frame).
- `frame_done`  out  1: one-cycle pulse at frame end.

## Operation
States: IDLE, CLEAR, RUN, STEP_Y, DONE.
- IDLE: all outputs 0; `line` holds 0. `start` -> CLEAR and latches `period_q`.
- CLEAR: `gen_rst`=1 for exactly one cycle; prescaler, `x_cnt` and `line` are cleared; next state RUN.
- RUN:
  - Prescaler counts 0..`period_q`-1.
  - In the cycle it equals `period_q`-1, `ena_x`=1, the prescaler wraps to 0, and `x_cnt` increments.
  - When that strobe makes `x_cnt`=2^N-1: if `line`=2^N-1 go to DONE, otherwise go to STEP_Y.
  - In both cases `x_cnt` clears.
- STEP_Y: `ena_y`=1 for one cycle, `line` increments, prescaler is at 0; next state RUN.
- DONE: `frame_done`=1 for one cycle; next state per Configuration.
- Pause:
  - While `pause`=1 in RUN, the prescaler and counters hold and `ena_x`=0.
  - Pause has no effect in CLEAR, STEP_Y or DONE, so those states always complete.
- Priority: `rst` > `stop` > `start`/`pause`.
  - `stop` in any state goes to IDLE; no strobe is issued in that cycle.
  - `start` while busy is ignored.
  - `start` and `stop` in the same cycle while in IDLE: stay in IDLE.
- Per frame: (2^N-1)·2^N `ena_x` strobes, 2^N-1 `ena_y` strobes, exactly one `frame_done`.
- Arithmetic: the prescaler and `x_cnt` are unsigned and never wrap past their terminal values. `line` saturates at 2^N-1 and cannot overflow.

## Timing
- All outputs are registered, decoded from state and counter values; there is no combinational path from the inputs.
- Reset values: state IDLE, and all outputs 0 (including `line` and `gen_rst`).
- Cycle numbering: `start` is sampled at edge 0, so cycle 1 is CLEAR (`gen_rst`=1) and cycles from 2 onward are RUN.
- The first `ena_x` is in cycle 1+`period_q`.
- `ena_x` and `ena_y` are never high in the same cycle.
- Between two consecutive `ena_x` strobes on one line there are exactly `period_q`-1 cycles (with no pause).
- `ena_y` immediately follows the line's last `ena_x`. The next `ena_x` follows `period_q` cycles after `ena_y`.
- `rst` mid-frame: IDLE on the next cycle. The generators are not reset by this block until the next `start`.

## Configuration
- Macro `SWEEP_CONTROLLER_LOOP_EN`.
- Defined: DONE -> RUN with `x_cnt` and `line` cleared and no `gen_rst`. The Y generator is then at its endpoint, so the next frame sweeps in the reverse direction. Frames continue until `stop` or `rst`, and `busy` stays high throughout.
- Undefined: DONE -> IDLE. A single frame is swept per `start`.

## Structure
- Package `sweep_pkg` holds:
  - the `sweep_state_t` enum (IDLE, CLEAR, RUN, STEP_Y, DONE);
  - a localparam function giving the terminal count (2^N-1).
- Sub-module `tick_divider` (PRESCALE_W-bit counter with `load`/`hold`/`clear` that emits a `tick` at `period`-1) implements the prescaler. The FSM and the step counters stay in `sweep_controller`.

## Test plan
Use N=3 unless stated.
1. Reset, then `period`=1, `start` pulse -> `gen_rst` in cycle 1. Expect 56 `ena_x`, 7 `ena_y`, and `line` ending at 7. `frame_done` is in cycle 65, then IDLE with `busy`=0.
2. `period`=4 -> first `ena_x` in cycle 5. Each line's 7 strobes are 4 cycles apart. `ena_y` is in the cycle after the 7th strobe, and the next `ena_x` is 4 cycles after `ena_y`.
3. `period`=0 -> identical behaviour to `period`=1. Change `period` mid-frame to 9 -> spacing stays unchanged.
4. `pause` high for 10 cycles mid-line, `period`=2 -> no strobes during the pause. The strobe that was due resumes with the remaining prescaler count; the total per frame stays at 56/7.
5. `stop` during STEP_Y, and separately `rst` during RUN -> IDLE next cycle with all outputs 0. A repeated `start` during RUN is ignored, with no extra `gen_rst`.
6. With `SWEEP_CONTROLLER_LOOP_EN` defined -> two consecutive `frame_done` pulses 64 cycles apart (`period`=1). There is no `gen_rst` after the first, and `busy` stays high until `stop`.
